seq_divider: RTL

Multi-cycle, exact unsigned integer divider with a start/done handshake that produces both quotient and remainder. It replaces fixed-constant approximate division in the score/timer datapath. Binary-to-decimal digit extraction for the display path issues one request per digit with divisor 10. Dividend and divisor width are parametrised, and a single restoring subtract-shift step executes per clock.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seqdiv_defs.vh | 7 +
 rtl/seqdiv_step.sv | 19 +
 rtl/seq_divider.sv | 133 +++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Types and constants for the sequential restoring divider.
// Pulls state encodings and counter sizing from seqdiv_defs.vh.
package seq_divider_pkg;
`include "seqdiv_defs.vh"

  typedef enum logic {
    IDLE = `SEQDIV_IDLE,
    RUN  = `SEQDIV_RUN
  } state_e;

  function automatic int cnt_w(input int w);
    return `SEQDIV_CNT_W(w);
  endfunction
endpackage

// File: rtl/seqdiv_defs.vh
// Shared encodings and sizing helpers for the sequential divider.
`ifndef SEQDIV_DEFS_VH
`define SEQDIV_DEFS_VH
`define SEQDIV_IDLE 1'b0
`define SEQDIV_RUN  1'b1
`define SEQDIV_CNT_W(w) ($clog2(w) + 1)
`endif

// File: rtl/seqdiv_step.sv
// One combinational restoring subtract-shift step.
module seqdiv_step #(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);
  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] dvs_ext;

  assign trial   = {rem_i, bit_i};
  assign dvs_ext = {2'b00, dvs_i};
  assign q_o     = (trial >= dvs_ext);
  assign rem_o   = q_o ? (WIDTH+1)'(trial - dvs_ext)
                       : trial[WIDTH:0];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider, one restoring step per clock.
// Define SEQDIV_ROUND_EN for round-half-up quotient.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dzp_q, dzp_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_nx;
  logic             qbit;
  logic [WIDTH-1:0] q_fl;
  logic [WIDTH-1:0] q_fin;

  seqdiv_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (shf_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .q_o   (qbit)
  );

  // Quotient bits fill the shift register from the LSB.
  assign q_fl = {shf_q[WIDTH-2:0], qbit};

`ifdef SEQDIV_ROUND_EN
  logic rnd;
  assign rnd   = ({rem_nx, 1'b0} >= {2'b00, dvs_q})
               && (q_fl != '1);
  assign q_fin = q_fl + WIDTH'(rnd);
`else
  assign q_fin = q_fl;
`endif

  always_comb begin
    state_d = state_q;
    shf_d   = shf_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dzp_d   = 1'b0;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
    // Zero divisor completes one cycle after load, never entering RUN.
    if (dzp_q) begin
      done_d = 1'b1;
      quo_d  = '1;
      rmd_d  = shf_q;
      dz_d   = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shf_d = dividend;
          dvs_d = divisor;
          rem_d = '0;
          cnt_d = '0;
          if (divisor == '0) dzp_d = 1'b1;
          else state_d = RUN;
        end
      end
      RUN: begin
        shf_d = q_fl;
        rem_d = rem_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          quo_d   = q_fin;
          rmd_d   = rem_nx[WIDTH-1:0];
          dz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shf_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dzp_q   <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shf_q   <= shf_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dzp_q   <= dzp_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;
endmodule
